jtag_master: RTL and testbench

JTAG initiator that drives the four-wire TAP port of a debug target from a simple command/response handshake. It generates TCK, sequences TMS through the TAP state machine, shifts TDI and captures TDO for IR and DR scans. It is used as the bench-side and bridge-side driver for the SoC debug TAP, in place of an external probe.

---
 rtl/jtag_master.sv | 185 ++++++++++++++++++
 tb/tb_jtag_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_master.sv
// JTAG initiator: turns command/response handshakes into TAP reset, IR scan and
// DR scan sequences on TCK/TMS/TDI, capturing TDO into the response word.
`timescale 1ns/1ps
module jtag_master #(
  parameter int unsigned MAX_LEN = 32,
  parameter int unsigned CLK_DIV = 2,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_type,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               jtag_tck,
  output logic               jtag_tms,
  output logic               jtag_tdi,
  input  logic               jtag_tdo
);

  localparam int unsigned DIV_W = $clog2(2 * CLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, NAV, SHIFT, EXIT, RESP} state_t;
  typedef enum logic [1:0] {CMD_RESET = 2'b00, CMD_IR = 2'b01, CMD_DR = 2'b10, CMD_NOP = 2'b11} cmd_t;

  state_t             state_q, state_d;
  cmd_t               typ_q, typ_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   bits_left_q, bits_left_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] mask_q, mask_d;
  logic [MAX_LEN-1:0] rsp_q, rsp_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [2:0]         seq_left_q, seq_left_d;
  logic [5:0]         seq_tms_q, seq_tms_d;
  logic               tck_q, tck_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;

  logic [LEN_W-1:0]   len_clamped;
  logic               zero_cmd;
  logic               tck_rise;
  logic               tck_fall;

  assign len_clamped = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
  assign zero_cmd    = (typ_q == CMD_NOP) || ((typ_q != CMD_RESET) && (len_q == '0));
  // The divider starts at 0 on acceptance but wraps to 1 after each falling edge,
  // so the first low phase is one cycle longer and the busy time is N*2*CLK_DIV+1.
  assign tck_rise    = (div_q == DIV_W'(CLK_DIV));
  assign tck_fall    = (div_q == DIV_W'(2 * CLK_DIV));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      typ_q       <= CMD_NOP;
      len_q       <= '0;
      bits_left_q <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      rsp_q       <= '0;
      div_q       <= '0;
      seq_left_q  <= '0;
      seq_tms_q   <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      typ_q       <= typ_d;
      len_q       <= len_d;
      bits_left_q <= bits_left_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rsp_q       <= rsp_d;
      div_q       <= div_d;
      seq_left_q  <= seq_left_d;
      seq_tms_q   <= seq_tms_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    typ_d       = typ_q;
    len_d       = len_q;
    bits_left_d = bits_left_q;
    data_d      = data_q;
    mask_d      = mask_q;
    rsp_d       = rsp_q;
    div_d       = div_q;
    seq_left_d  = seq_left_q;
    seq_tms_d   = seq_tms_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = NAV;
          typ_d   = cmd_t'(cmd_type);
          len_d   = len_clamped;
          data_d  = cmd_data;
          mask_d  = MAX_LEN'(1);
          rsp_d   = '0;
          div_d   = '0;
          tdi_d   = 1'b0;
          if (!((cmd_type == 2'b11) || ((cmd_type != 2'b00) && (len_clamped == '0))))
            tms_d = 1'b1;
          case (cmd_type)
            2'b00: begin seq_tms_d = 6'b011111; seq_left_d = 3'd5; end
            2'b01: begin seq_tms_d = 6'b000011; seq_left_d = 3'd3; end
            default: begin seq_tms_d = 6'b000001; seq_left_d = 3'd2; end
          endcase
        end
      end

      NAV, SHIFT, EXIT: begin
        if ((state_q == NAV) && zero_cmd) begin
          state_d = RESP;
        end else begin
          div_d = div_q + 1'b1;
          if (tck_rise) begin
            tck_d = 1'b1;
            if (state_q == SHIFT)
              rsp_d = rsp_q | (mask_q & {MAX_LEN{jtag_tdo}});
          end
          if (tck_fall) begin
            tck_d = 1'b0;
            div_d = DIV_W'(1);
            if (state_q == SHIFT) begin
              mask_d = mask_q << 1;
              data_d = data_q >> 1;
              if (bits_left_q == '0) begin
                state_d    = EXIT;
                seq_tms_d  = 6'b000001;
                seq_left_d = 3'd1;
                tms_d      = 1'b1;
                tdi_d      = 1'b0;
              end else begin
                bits_left_d = bits_left_q - 1'b1;
                tms_d       = (bits_left_q == LEN_W'(1));
                tdi_d       = data_d[0];
              end
            end else if (seq_left_q != 3'd0) begin
              seq_left_d = seq_left_q - 3'd1;
              seq_tms_d  = seq_tms_q >> 1;
              tms_d      = seq_tms_q[1];
            end else if ((state_q == NAV) && (typ_q != CMD_RESET)) begin
              state_d     = SHIFT;
              bits_left_d = len_q - 1'b1;
              tms_d       = (len_q == LEN_W'(1));
              tdi_d       = data_q[0];
            end else begin
              state_d = RESP;
              tms_d   = 1'b0;
              tdi_d   = 1'b0;
            end
          end
        end
      end

      RESP: begin
        if (rsp_ready)
          state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_q;
  assign jtag_tck  = tck_q;
  assign jtag_tms  = tms_q;
  assign jtag_tdi  = tdi_q;

endmodule

// File: tb/tb_jtag_master.sv
// Self-checking bench for jtag_master: command table + scoreboard queue, a
// behavioural TAP target model, and a TCK edge monitor.
`timescale 1ns/1ps
module tb_jtag_master;
  localparam int unsigned MAX_LEN = 32;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned LEN_W   = 6;
  localparam int unsigned TCLK    = 10;

  logic               clk_sys   = 1'b0;
  logic               reset_n   = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_type  = 2'b00;
  logic [LEN_W-1:0]   cmd_len   = '0;
  logic [MAX_LEN-1:0] cmd_data  = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               jtag_tck;
  logic               jtag_tms;
  logic               jtag_tdi;
  logic               jtag_tdo  = 1'b0;

  always #5 clk_sys = ~clk_sys;

  jtag_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi), .jtag_tdo(jtag_tdo)
  );

  // Target TAP model: 5-bit IR (capture 00001), one 32-bit DR preloaded with IDCODE.
  typedef enum logic [3:0] {TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
                            SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR} tap_t;
  tap_t        tap_st  = TLR;
  logic [31:0] m_dr    = 32'h249511C3;
  logic [31:0] m_dr_sr = '0;
  logic [4:0]  m_ir    = 5'b00001;
  logic [4:0]  m_ir_sr = '0;

  function automatic tap_t next_tap(input tap_t s, input logic tms);
    case (s)
      TLR:    return tms ? TLR    : RTI;
      RTI:    return tms ? SEL_DR : RTI;
      SEL_DR: return tms ? SEL_IR : CAP_DR;
      CAP_DR: return tms ? EX1_DR : SH_DR;
      SH_DR:  return tms ? EX1_DR : SH_DR;
      EX1_DR: return tms ? UPD_DR : PA_DR;
      PA_DR:  return tms ? EX2_DR : PA_DR;
      EX2_DR: return tms ? UPD_DR : SH_DR;
      UPD_DR: return tms ? SEL_DR : RTI;
      SEL_IR: return tms ? TLR    : CAP_IR;
      CAP_IR: return tms ? EX1_IR : SH_IR;
      SH_IR:  return tms ? EX1_IR : SH_IR;
      EX1_IR: return tms ? UPD_IR : PA_IR;
      PA_IR:  return tms ? EX2_IR : PA_IR;
      EX2_IR: return tms ? UPD_IR : SH_IR;
      default: return tms ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge jtag_tck) begin
    case (tap_st)
      CAP_DR: m_dr_sr = m_dr;
      SH_DR:  m_dr_sr = {jtag_tdi, m_dr_sr[31:1]};
      UPD_DR: m_dr    = m_dr_sr;
      CAP_IR: m_ir_sr = 5'b00001;
      SH_IR:  m_ir_sr = {jtag_tdi, m_ir_sr[4:1]};
      UPD_IR: m_ir    = m_ir_sr;
      default: ;
    endcase
    tap_st = next_tap(tap_st, jtag_tms);
  end

  always @(negedge jtag_tck)
    jtag_tdo = (tap_st == SH_DR) ? m_dr_sr[0] : (tap_st == SH_IR) ? m_ir_sr[0] : 1'b0;

  // TCK monitor: per-rise TMS/TDI history plus pulse-width and period violations.
  int unsigned tck_total = 0;
  int unsigned hi_bad    = 0;
  int unsigned per_bad   = 0;
  time         last_rise = 0;
  logic        tms_hist [1024];
  logic        tdi_hist [1024];

  always @(posedge jtag_tck) begin
    tms_hist[10'(tck_total)] = jtag_tms;
    tdi_hist[10'(tck_total)] = jtag_tdi;
    if ((tck_total > 0) && (($time - last_rise) < 64'(2 * CLK_DIV * TCLK)))
      per_bad++;
    last_rise = $time;
    tck_total++;
  end

  always @(negedge jtag_tck)
    if (($time - last_rise) != 64'(CLK_DIV * TCLK))
      hi_bad++;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  typ;
    logic [5:0]  len;
    logic [31:0] data;
    int unsigned slen;
    int unsigned n_tck;
    int unsigned nav_n;
    logic [63:0] tms;
    logic [31:0] rsp;
  } vec_t;

  vec_t        vecs [10];
  vec_t        sb_q [$];
  int unsigned cmd_tck0, hi0, per0;

  task automatic issue(input vec_t v, input bit push);
    int unsigned n = 0;
    @(negedge clk_sys);
    cmd_valid = 1'b1;
    cmd_type  = v.typ;
    cmd_len   = v.len;
    cmd_data  = v.data;
    while (!cmd_ready && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    chk("cmd_accept", 64'(cmd_ready), 64'(1));
    @(posedge clk_sys);
    cmd_tck0 = tck_total;
    hi0      = hi_bad;
    per0     = per_bad;
    if (push) sb_q.push_back(v);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic collect(input bit ack);
    vec_t        e;
    int unsigned cyc = 0;
    logic [63:0] tms_act;
    logic [31:0] tdi_act, msk;
    while (!rsp_valid && cyc < 400) begin
      @(posedge clk_sys);
      #1;
      cyc++;
    end
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard: got empty queue expected pending entry");
      $fatal(1);
    end
    e = sb_q.pop_front();
    chk("latency",   64'(cyc), 64'(2 * CLK_DIV * e.n_tck + 1));
    chk("rsp_data",  64'(rsp_data), 64'(e.rsp));
    chk("tck_count", 64'(tck_total - cmd_tck0), 64'(e.n_tck));
    chk("tck_idle_at_rsp", 64'(jtag_tck), 64'(0));
    chk("tck_high_width",  64'(hi_bad - hi0), 64'(0));
    chk("tck_period",      64'(per_bad - per0), 64'(0));
    if (e.n_tck > 0) begin
      tms_act = '0;
      for (int unsigned i = 0; i < e.n_tck && i < 64; i++)
        tms_act = tms_act | (64'(tms_hist[10'(cmd_tck0 + i)]) << i);
      chk("tms_seq",    tms_act, e.tms);
      chk("tms_at_rsp", 64'(jtag_tms), 64'(0));
      chk("tap_in_rti", 64'(tap_st == RTI), 64'(1));
    end
    if (e.slen > 0) begin
      tdi_act = '0;
      for (int unsigned i = 0; i < e.slen; i++)
        tdi_act = tdi_act | (32'(tdi_hist[10'(cmd_tck0 + e.nav_n + i)]) << i);
      msk = (e.slen >= 32) ? '1 : ((32'h1 << e.slen) - 32'h1);
      chk("tdi_seq", 64'(tdi_act), 64'(e.data & msk));
    end
    if (ack) begin
      @(negedge clk_sys);
      rsp_ready = 1'b1;
      @(posedge clk_sys);
      #1 rsp_ready = 1'b0;
      chk("cmd_ready_after_ack", 64'(cmd_ready), 64'(1));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    int unsigned t0, n;

    vecs[0] = '{typ: 2'b00, len: 6'd0,  data: 32'h0,        slen: 0,  n_tck: 6,  nav_n: 6, tms: 64'h1F,          rsp: 32'h0};
    vecs[1] = '{typ: 2'b01, len: 6'd5,  data: 32'h1,        slen: 5,  n_tck: 11, nav_n: 4, tms: 64'h303,         rsp: 32'h1};
    vecs[2] = '{typ: 2'b10, len: 6'd32, data: 32'h0,        slen: 32, n_tck: 37, nav_n: 3, tms: 64'hC_0000_0001, rsp: 32'h249511C3};
    vecs[3] = '{typ: 2'b10, len: 6'd8,  data: 32'hA5,       slen: 8,  n_tck: 13, nav_n: 3, tms: 64'hC01,         rsp: 32'h0};
    vecs[4] = '{typ: 2'b10, len: 6'd32, data: 32'h12345678, slen: 32, n_tck: 37, nav_n: 3, tms: 64'hC_0000_0001, rsp: 32'hA5000000};
    vecs[5] = '{typ: 2'b10, len: 6'd0,  data: 32'hFFFF,     slen: 0,  n_tck: 0,  nav_n: 3, tms: 64'h0,           rsp: 32'h0};
    vecs[6] = '{typ: 2'b11, len: 6'd5,  data: 32'h1F,       slen: 0,  n_tck: 0,  nav_n: 0, tms: 64'h0,           rsp: 32'h0};
    vecs[7] = vecs[0];
    vecs[8] = '{typ: 2'b10, len: 6'd32, data: 32'h13579BDF, slen: 32, n_tck: 37, nav_n: 3, tms: 64'hC_0000_0001, rsp: 32'h0};
    vecs[9] = '{typ: 2'b10, len: 6'd40, data: 32'hCAFEF00D, slen: 32, n_tck: 37, nav_n: 3, tms: 64'hC_0000_0001, rsp: 32'h13579BDF};

    // Reset state and quiet TCK while idle.
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("reset_tck",       64'(jtag_tck),  64'(0));
    chk("reset_tms",       64'(jtag_tms),  64'(1));
    chk("reset_tdi",       64'(jtag_tdi),  64'(0));
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_data",  64'(rsp_data),  64'(0));
    reset_n = 1'b1;
    t0 = tck_total;
    repeat (20) @(negedge clk_sys);
    chk("idle_no_tck",     64'(tck_total - t0), 64'(0));
    chk("idle_tms_high",   64'(jtag_tms), 64'(1));

    // TAP reset, IR scan, IDCODE DR scan.
    for (int unsigned i = 0; i < 3; i++) begin
      issue(vecs[i], 1'b1);
      collect(1'b1);
    end
    chk("model_ir", 64'(m_ir), 64'(5'b00001));
    chk("model_dr", 64'(m_dr), 64'(0));

    // Response backpressure with a second command waiting.
    issue(vecs[3], 1'b1);
    collect(1'b0);
    @(negedge clk_sys);
    cmd_valid = 1'b1;
    cmd_type  = vecs[4].typ;
    cmd_len   = vecs[4].len;
    cmd_data  = vecs[4].data;
    t0 = tck_total;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      chk("bp_rsp_data",  64'(rsp_data),  64'(vecs[3].rsp));
      chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    chk("bp_no_tck", 64'(tck_total - t0), 64'(0));
    rsp_ready = 1'b1;
    @(posedge clk_sys);
    #1 rsp_ready = 1'b0;
    chk("bp_rsp_done",  64'(rsp_valid), 64'(0));
    chk("bp_idle",      64'(cmd_ready), 64'(1));
    @(posedge clk_sys);
    cmd_tck0 = tck_total;
    hi0      = hi_bad;
    per0     = per_bad;
    sb_q.push_back(vecs[4]);
    #1 cmd_valid = 1'b0;
    chk("bp_second_accepted", 64'(cmd_ready), 64'(0));
    collect(1'b1);
    chk("model_dr_bp", 64'(m_dr), 64'(32'h12345678));

    // Asynchronous reset in the middle of a 32-bit DR shift, with TCK high.
    v = vecs[4];
    v.data = '1;
    issue(v, 1'b0);
    repeat (28) @(posedge clk_sys);
    n = 0;
    while (!jtag_tck && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    chk("mid_tck_high", 64'(jtag_tck), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_reset_tck",       64'(jtag_tck),  64'(0));
    chk("mid_reset_tms",       64'(jtag_tms),  64'(1));
    chk("mid_reset_tdi",       64'(jtag_tdi),  64'(0));
    chk("mid_reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("mid_reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_reset_rsp_data",  64'(rsp_data),  64'(0));
    t0 = tck_total;
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    chk("post_reset_no_tck", 64'(tck_total - t0), 64'(0));

    // Zero-length DR scan, no-op, then TAP reset to recover the target.
    for (int unsigned i = 5; i < 8; i++) begin
      issue(vecs[i], 1'b1);
      collect(1'b1);
    end

    // Load a known DR, then a len=40 scan that must behave as len=32.
    v = vecs[8];
    v.rsp = m_dr;
    issue(v, 1'b1);
    collect(1'b1);
    issue(vecs[9], 1'b1);
    collect(1'b1);
    chk("model_dr_clamped", 64'(m_dr), 64'(32'hCAFEF00D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
